// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared constants, types and threshold helpers for sfifo_param.
// The default types track the default build (8-bit words, 16 entries).
package sfifo_pkg;

  localparam int SFIFO_DATA_WIDTH = 8;
  localparam int SFIFO_DEPTH      = 16;
  localparam int SFIFO_AW         = $clog2(SFIFO_DEPTH);
  localparam int SFIFO_AE_THRESH  = 2;

  typedef logic [SFIFO_DATA_WIDTH-1:0] data_t;
  typedef logic [SFIFO_AW:0]           ptr_t;
  typedef logic [SFIFO_AW:0]           cnt_t;

  // Fill level at or above a threshold (almost_full style compare).
  function automatic logic level_ge(input int unsigned level, input int unsigned thresh);
    return (level >= thresh) ? 1'b1 : 1'b0;
  endfunction

  // Fill level at or below a threshold (almost_empty style compare).
  function automatic logic level_le(input int unsigned level, input int unsigned thresh);
    return (level <= thresh) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: simple dual-port register array for sfifo_param.
// Synchronous write port, asynchronous read port, contents are not reset.
module sfifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port: store the word on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with fill count, almost
// flags and sticky overflow/underflow errors.
// Optional macro SFIFO_FWFT_EN selects first-word-fall-through reads;
// without it data_out is registered and updates one edge after a pop.
// DEPTH must be a power of two, minimum 4.
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = SFIFO_DATA_WIDTH,
  parameter int DEPTH      = SFIFO_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = SFIFO_AE_THRESH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    err_clr,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the address bits match.
  logic [AW:0]           wr_ptr_r;
  logic [AW:0]           rd_ptr_r;
  logic [AW:0]           count_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  pop_ok_s;
  logic                  push_ok_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [AW:0]           ptr_one_s;

  assign ptr_one_s = {{AW{1'b0}}, 1'b1};

  // Status decodes look only at registered state, never at push/pop.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  // On empty the pop is always rejected, even alongside a push.
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);

  sfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata_s)
  );

  // Write pointer: advance on each accepted push, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
    end else if (push_ok_s) begin
      wr_ptr_r <= wr_ptr_r + ptr_one_s;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer: advance on each accepted pop, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (pop_ok_s) begin
      rd_ptr_r <= rd_ptr_r + ptr_one_s;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Fill level: net change of accepted pushes and pops this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {(AW+1){1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + ptr_one_s;
        2'b01:   count_r <= count_r - ptr_one_s;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky errors: a new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push & ~push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (pop & empty_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

`ifdef SFIFO_FWFT_EN
  // Head of the queue is presented directly; meaningless while empty.
  assign data_out = rdata_s;
`else
  logic [DATA_WIDTH-1:0] dout_r;

  // Registered read: capture the head word on the pop edge, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else if (pop_ok_s) begin
      dout_r <= rdata_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign data_out = dout_r;
`endif

  assign full         = full_s;
  assign empty        = empty_s;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign almost_full  = level_ge(32'(count_r), AF_THRESH);
  assign almost_empty = level_le(32'(count_r), AE_THRESH);

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed self-checking bench for sfifo_param
// (DATA_WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2). Honours SFIFO_FWFT_EN.
module tb_sfifo_param;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       err_clr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sfifo_param #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AF_THRESH  (14),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .err_clr      (err_clr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one word and compare it to the expected head value.
  task automatic pop_expect(input string tag, input logic [7:0] exp);
    pop = 1'b1;
`ifdef SFIFO_FWFT_EN
    check(tag, 32'(data_out), 32'(exp));
    tick();
`else
    tick();
    check(tag, 32'(data_out), 32'(exp));
`endif
    pop = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
`ifndef SFIFO_FWFT_EN
    check("rst_dout", 32'(data_out), 32'h00);
`endif
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);

    // 2. fill to full, watching the threshold flags
    for (int i = 1; i <= 16; i++) begin
      push    = 1'b1;
      data_in = 8'(i);
      tick();
      check("fill_count", 32'(count), 32'(i));
      check("fill_aempty", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      check("fill_afull", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
    end
    data_in = 8'hAA;
    tick();
    push = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      pop_expect("drain_data", 8'(i));
      check("drain_count", 32'(count), 32'(16 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // 3. underflow and sticky clear behaviour
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_count", 32'(count), 32'd0);
`ifndef SFIFO_FWFT_EN
    check("udf_dout_hold", 32'(data_out), 32'h10);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_udf", 32'(underflow), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    err_clr = 1'b1;
    pop     = 1'b1;
    tick();
    err_clr = 1'b0;
    pop     = 1'b0;
    check("set_beats_clr", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_udf2", 32'(underflow), 32'd0);
    // push and pop together on empty: push taken, pop rejected
    push    = 1'b1;
    pop     = 1'b1;
    data_in = 8'h77;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    check("pp_empty_udf", 32'(underflow), 32'd1);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_flag", 32'(empty), 32'd0);
    pop_expect("pp_empty_data", 8'h77);
    check("pp_empty_after", 32'(empty), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 4. full with simultaneous push and pop, then drain across the wrap
    for (int i = 1; i <= 16; i++) begin
      push    = 1'b1;
      data_in = 8'(i);
      tick();
    end
    push = 1'b0;
    check("refill_full", 32'(full), 32'd1);
    for (int k = 0; k < 8; k++) begin
      push    = 1'b1;
      data_in = 8'(8'h20 + k);
      pop_expect("pp_full_data", 8'(k + 1));
      push = 1'b0;
      check("pp_full_count", 32'(count), 32'd16);
    end
    check("pp_full_ovf", 32'(overflow), 32'd0);
    check("pp_full_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop_expect("wrap_data", (i < 8) ? 8'(9 + i) : 8'(8'h20 + i - 8));
    end
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_count", 32'(count), 32'd0);

    // 5. asynchronous reset mid-operation
    pop = 1'b1;
    tick();
    pop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push    = 1'b1;
      data_in = 8'(8'h40 + i);
      tick();
    end
    push = 1'b0;
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_udf", 32'(underflow), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_udf", 32'(underflow), 32'd0);
    check("arst_aempty", 32'(almost_empty), 32'd1);
`ifndef SFIFO_FWFT_EN
    check("arst_dout", 32'(data_out), 32'h00);
`endif
    #1;
    rst = 1'b0;
    tick();
    push    = 1'b1;
    data_in = 8'h33;
    tick();
    push = 1'b0;
    pop_expect("post_rst_data", 8'h33);
    check("post_rst_empty", 32'(empty), 32'd1);

`ifdef SFIFO_FWFT_EN
    // 6. first-word-fall-through visibility
    push    = 1'b1;
    data_in = 8'h5A;
    tick();
    push = 1'b0;
    check("fwft_vis", 32'(data_out), 32'h5A);
    check("fwft_nonempty", 32'(empty), 32'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("fwft_pop_empty", 32'(empty), 32'd1);
    push    = 1'b1;
    data_in = 8'h11;
    tick();
    data_in = 8'h22;
    tick();
    push = 1'b0;
    check("fwft_head1", 32'(data_out), 32'h11);
    tick();
    check("fwft_hold", 32'(data_out), 32'h11);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("fwft_head2", 32'(data_out), 32'h22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
